// File: rtl/ic_cpu_bus_arb2.sv
// ic_cpu_bus_arb2: two-master to one-slave CPU bus arbiter with owner FIFO response routing (round robin under IC_ARB_ROUND_ROBIN_EN)
module ic_cpu_bus_arb2 #(
  parameter int OUTSTANDING = 2,
  parameter int PTR_W = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        m0_req,
  output logic        m0_gnt,
  input  logic        m0_wen,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_recv,
  input  logic        m0_ack,
  output logic        m0_error,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  output logic        m1_gnt,
  input  logic        m1_wen,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_recv,
  input  logic        m1_ack,
  output logic        m1_error,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  input  logic        s_gnt,
  output logic        s_wen,
  output logic [3:0]  s_strb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_recv,
  output logic        s_ack,
  input  logic        s_error,
  input  logic [31:0] s_rdata,
  output logic        rsp_orphan
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING-1);
  logic lock, lock_id, sel, sel_req, full, empty, push, pop, head;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0] count;
  logic [OUTSTANDING-1:0] owner;
`ifdef IC_ARB_ROUND_ROBIN_EN
  logic last_winner;
  // pick the winner: held lock first, then alternate on contention
  always_comb sel = lock ? lock_id : (m0_req && m1_req) ? !last_winner : m1_req;
  // remember who won the most recent grant
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) last_winner <= 1'b0;
    else if (push) last_winner <= sel;
`else
  // pick the winner: held lock first, then data port over instruction port
  always_comb sel = lock ? lock_id : m1_req;
`endif
  // request mux, grant steering and response routing toward the FIFO head owner
  always_comb begin
    sel_req  = sel ? m1_req : m0_req;
    full     = count == FULL_CNT;
    empty    = count == '0;
    s_req    = sel_req && !full;
    s_wen    = sel ? m1_wen : m0_wen;
    s_strb   = sel ? m1_strb : m0_strb;
    s_wdata  = sel ? m1_wdata : m0_wdata;
    s_addr   = sel ? m1_addr : m0_addr;
    m0_gnt   = !sel && s_gnt && !full;
    m1_gnt   = sel && s_gnt && !full;
    push     = s_req && s_gnt;
    head     = owner[rptr];
    m0_recv  = s_recv && !empty && !head;
    m1_recv  = s_recv && !empty && head;
    m0_rdata = (!empty && !head) ? s_rdata : '0;
    m1_rdata = (!empty && head) ? s_rdata : '0;
    m0_error = !empty && !head && s_error;
    m1_error = !empty && head && s_error;
    s_ack    = empty ? s_recv : head ? m1_ack : m0_ack;
    pop      = s_recv && s_ack && !empty;
  end
  // owner FIFO: record who was granted, retire on each accepted response
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      owner <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) owner[wptr] <= sel;
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
      if (pop) rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  // hold the bus for a master whose request was refused until it is granted
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else if (push) begin
      lock <= 1'b0;
    end else if (sel_req && !s_gnt) begin
      lock    <= 1'b1;
      lock_id <= sel;
    end
  // flag any response arriving with nobody waiting for it
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) rsp_orphan <= 1'b0;
    else if (s_recv && empty) rsp_orphan <= 1'b1;
endmodule

// File: tb/tb_ic_cpu_bus_arb2.sv
// tb_ic_cpu_bus_arb2: directed and randomized checks of the two-master arbiter against a queue-based model
module tb_ic_cpu_bus_arb2;
`ifdef IC_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic req[2], wen[2], ack[2], gnt[2], recv[2], err[2];
  logic [3:0] strb[2];
  logic [31:0] wdata[2], addr[2], rd[2];
  logic s_req, s_gnt, s_wen, s_recv, s_ack, s_error, rsp_orphan;
  logic [3:0] s_strb;
  logic [31:0] s_wdata, s_addr, s_rdata;
  int passed = 0, total = 0;
  bit q[$];
  bit lk_v, lk_id, lw, sel, full, grant, h;

  ic_cpu_bus_arb2 dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(req[0]), .m0_gnt(gnt[0]), .m0_wen(wen[0]), .m0_strb(strb[0]), .m0_wdata(wdata[0]),
    .m0_addr(addr[0]), .m0_recv(recv[0]), .m0_ack(ack[0]), .m0_error(err[0]), .m0_rdata(rd[0]),
    .m1_req(req[1]), .m1_gnt(gnt[1]), .m1_wen(wen[1]), .m1_strb(strb[1]), .m1_wdata(wdata[1]),
    .m1_addr(addr[1]), .m1_recv(recv[1]), .m1_ack(ack[1]), .m1_error(err[1]), .m1_rdata(rd[1]),
    .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata), .s_addr(s_addr),
    .s_recv(s_recv), .s_ack(s_ack), .s_error(s_error), .s_rdata(s_rdata), .rsp_orphan(rsp_orphan)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [71:0] fld(input bit m);
    return {3'b0, wen[m], strb[m], wdata[m], addr[m]};
  endfunction

  function automatic logic [71:0] sfld();
    return {3'b0, s_wen, s_strb, s_wdata, s_addr};
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; ack[m] = 1'b0;
    end
    s_gnt = 1'b0; s_recv = 1'b0; s_error = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    q.delete(); lk_v = 1'b0; lk_id = 1'b0; lw = 1'b0;
  endtask

  initial begin
    idle();
    wen[0] = 1'b0; strb[0] = 4'h0; wdata[0] = 32'h0; addr[0] = 32'h1000_0000;
    wen[1] = 1'b1; strb[1] = 4'hC; wdata[1] = 32'hDEAD_BEEF; addr[1] = 32'h2000_0004;
    #2;
    chk("reset_s_req", s_req, 0);
    chk("reset_orphan", rsp_orphan, 0);
    chk("reset_recv", {recv[1], recv[0]}, 0);
    tick();
    g_resetn = 1'b1;
    // fixed priority and routing
    req[0] = 1'b1; req[1] = 1'b1; s_gnt = 1'b1;
    #2;
    chk("prio_m1_first", {gnt[1], gnt[0]}, 2'b10);
    chk("prio_fields_m1", sfld(), fld(1));
    tick();
    req[1] = 1'b0; s_recv = 1'b1; s_rdata = 32'hA5A5_0001; ack[1] = 1'b1;
    #2;
    chk("prio_m0_second", {gnt[1], gnt[0]}, 2'b01);
    chk("prio_fields_m0", sfld(), fld(0));
    chk("route_m1_recv", {recv[1], recv[0]}, 2'b10);
    chk("route_m1_rdata", rd[1], 32'hA5A5_0001);
    chk("route_m0_rdata_zero", rd[0], 0);
    tick();
    req[0] = 1'b0; ack[1] = 1'b0; ack[0] = 1'b1; s_rdata = 32'hA5A5_0000;
    #2;
    chk("route_m0_recv", {recv[1], recv[0]}, 2'b01);
    chk("route_m0_rdata", rd[0], 32'hA5A5_0000);
    chk("route_m1_rdata_zero", rd[1], 0);
    tick();
    idle();
    // lock
    req[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req[1] = 1'b1;
      #2;
      chk("lock_addr", s_addr, addr[0]);
      chk("lock_no_gnt", {gnt[1], gnt[0]}, 0);
      tick();
    end
    s_gnt = 1'b1;
    #2;
    chk("lock_addr_gnt", s_addr, addr[0]);
    chk("lock_m0_gnt", {gnt[1], gnt[0]}, 2'b01);
    tick();
    req[0] = 1'b0;
    #2;
    chk("lock_m1_after", {gnt[1], gnt[0]}, 2'b10);
    tick();
    req[1] = 1'b0;
    // full: FIFO now holds m0, m1
    req[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("full_s_req", s_req, 0);
      chk("full_gnt", gnt[0], 0);
      tick();
    end
    s_recv = 1'b1; ack[0] = 1'b1; s_rdata = 32'h0000_1234;
    #2;
    chk("full_pop_ack", s_ack, 1);
    chk("full_pop_recv", {recv[1], recv[0]}, 2'b01);
    chk("full_pop_no_gnt", {s_req, gnt[0]}, 0);
    tick();
    s_recv = 1'b0; ack[0] = 1'b0;
    #2;
    chk("full_regrant", {s_req, gnt[0]}, 2'b11);
    tick();
    req[0] = 1'b0; s_gnt = 1'b0;
    // backpressure: FIFO holds m1, m0
    s_recv = 1'b1; s_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("bp_recv", {recv[1], recv[0]}, 2'b10);
      chk("bp_ack", s_ack, 0);
      chk("bp_rdata", rd[1], 32'h5555_AAAA);
      tick();
    end
    ack[1] = 1'b1;
    #2;
    chk("bp_release", {s_ack, recv[1]}, 2'b11);
    tick();
    ack[1] = 1'b0; ack[0] = 1'b1;
    #2;
    chk("bp_next_head", {recv[1], recv[0], s_ack}, 3'b011);
    tick();
    idle();
    // orphan
    s_recv = 1'b1;
    #2;
    chk("orphan_drain", {s_ack, recv[1], recv[0]}, 3'b100);
    tick();
    s_recv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("orphan_sticky", rsp_orphan, 1);
      tick();
    end
    g_resetn = 1'b0;
    #1;
    chk("orphan_clear", rsp_orphan, 0);
    tick();
    g_resetn = 1'b1;
`ifdef IC_ARB_ROUND_ROBIN_EN
    // round robin under continuous contention
    do_reset();
    req[0] = 1'b1; req[1] = 1'b1; s_gnt = 1'b1; ack[0] = 1'b1; ack[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_recv = (i > 0);
      #2;
      chk("rr_order", {gnt[1], gnt[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
`endif
    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 1) == 1) begin
          req[m] = 1'b1; wen[m] = 1'($urandom); strb[m] = 4'($urandom);
          wdata[m] = $urandom; addr[m] = $urandom;
        end
        ack[m] = 1'($urandom);
      end
      s_gnt = $urandom_range(0, 3) != 0;
      s_recv = q.size() > 0 && $urandom_range(0, 1) == 1;
      s_rdata = $urandom; s_error = 1'($urandom);
      #2;
      sel = lk_v ? lk_id : (req[0] && req[1]) ? (RR ? !lw : 1'b1) : req[1];
      full = q.size() == 2;
      h = q.size() > 0 ? q[0] : 1'b0;
      chk("rnd_s_req", s_req, req[sel] && !full);
      if (req[sel] && !full) chk("rnd_fields", sfld(), fld(sel));
      chk("rnd_gnt", {gnt[1], gnt[0]}, (s_gnt && !full) ? (sel ? 2'b10 : 2'b01) : 2'b00);
      for (int m = 0; m < 2; m++) begin
        chk("rnd_recv", recv[m], s_recv && q.size() > 0 && h == m);
        chk("rnd_rdata", rd[m], (q.size() > 0 && h == m) ? s_rdata : 32'h0);
        chk("rnd_error", err[m], q.size() > 0 && h == m && s_error);
      end
      if (s_recv) chk("rnd_s_ack", s_ack, ack[h]);
      chk("rnd_orphan", rsp_orphan, 0);
      grant = req[sel] && !full && s_gnt;
      if (s_recv && ack[h]) void'(q.pop_front());
      if (grant) begin
        q.push_back(sel); lw = sel; lk_v = 1'b0;
      end else if (req[sel] && !s_gnt) begin
        lk_v = 1'b1; lk_id = sel;
      end
      tick();
      if (grant) req[sel] = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
